hazard_tag_pipe: RTL and testbench

Producer side of the pipeline hazard interface. It carries decode-stage register tags and control bits through the Execute, Memory and Writeback pipeline registers. It presents them as the RA1E/RA2E, WA3E/M/W, RegWriteM/W, MemtoRegE and PCSrcE/M/W signals the hazard unit consumes, and it applies the hazard unit's StallD/FlushE results back to its own E stage. It also keeps saturating stall, flush and retire counters for debug.

---
 rtl/hazard_tag_pipe_pkg.sv | 12 +
 rtl/hazard_tag_pipe_sat_counter.sv | 14 +
 rtl/hazard_tag_pipe.sv | 89 ++++++++
 tb/tb_hazard_tag_pipe.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hazard_tag_pipe_pkg.sv
// pipe_pkg: shared stage record and bubble constant for the hazard tag pipeline.
package pipe_pkg;
  localparam int TAG_W = 4;
  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memtoreg;
    logic             pcsrc;
    logic [TAG_W-1:0] wa3;
  } stage_ctrl_t;
  localparam stage_ctrl_t BUBBLE = '0;
endpackage

// File: rtl/hazard_tag_pipe_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that beats increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: carries decode tags/control through E/M/W for the hazard unit,
// applies FlushE to its own E stage and keeps saturating debug counters.
module hazard_tag_pipe
  import pipe_pkg::*;
#(
  parameter int REG_W = TAG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidD,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             CondExE,
  input  logic             StallD,
  input  logic             FlushE,
  input  logic             CntClr,
  output logic [REG_W-1:0] RA1E,
  output logic [REG_W-1:0] RA2E,
  output logic [REG_W-1:0] WA3E,
  output logic [REG_W-1:0] WA3M,
  output logic [REG_W-1:0] WA3W,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             PCSrcE,
  output logic             RegWriteM,
  output logic             MemtoRegM,
  output logic             PCSrcM,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic             PCSrcW,
  output logic             ValidE,
  output logic             ValidM,
  output logic             ValidW,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] RetireCnt
);
  stage_ctrl_t      r_e, r_m, r_w, w_d, w_m;
  logic [REG_W-1:0] r_ra1e, r_ra2e;
  always_comb begin
    w_d = '{valid: ValidD, regwrite: RegWriteD & ValidD, memtoreg: MemtoRegD & ValidD,
            pcsrc: PCSrcD & ValidD, wa3: WA3D};
    w_m = '{valid: r_e.valid, regwrite: r_e.regwrite & CondExE, memtoreg: r_e.memtoreg & CondExE,
            pcsrc: r_e.pcsrc & CondExE, wa3: r_e.wa3};
  end
  // StallD never holds E: a load-use stall always comes with FlushE, so E bubbles.
  always_ff @(posedge clk)
    if (reset) begin
      r_e    <= BUBBLE;
      r_m    <= BUBBLE;
      r_w    <= BUBBLE;
      r_ra1e <= '0;
      r_ra2e <= '0;
    end else begin
      r_e    <= FlushE ? BUBBLE : w_d;
      r_ra1e <= FlushE ? '0 : RA1D;
      r_ra2e <= FlushE ? '0 : RA2D;
      r_m    <= w_m;
      r_w    <= r_m;
    end
  assign RA1E      = r_ra1e;
  assign RA2E      = r_ra2e;
  assign WA3E      = r_e.wa3;
  assign WA3M      = r_m.wa3;
  assign WA3W      = r_w.wa3;
  assign RegWriteE = r_e.regwrite;
  assign MemtoRegE = r_e.memtoreg;
  assign PCSrcE    = r_e.pcsrc;
  assign RegWriteM = r_m.regwrite;
  assign MemtoRegM = r_m.memtoreg;
  assign PCSrcM    = r_m.pcsrc;
  assign RegWriteW = r_w.regwrite;
  assign MemtoRegW = r_w.memtoreg;
  assign PCSrcW    = r_w.pcsrc;
  assign ValidE    = r_e.valid;
  assign ValidM    = r_m.valid;
  assign ValidW    = r_w.valid;
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .reset(reset), .inc(StallD), .clr(CntClr), .cnt(StallCnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .clk(clk), .reset(reset), .inc(FlushE & ~StallD), .clr(CntClr), .cnt(FlushCnt));
  sat_counter #(.CNT_W(CNT_W)) u_retire (
    .clk(clk), .reset(reset), .inc(r_w.valid), .clr(CntClr), .cnt(RetireCnt));
endmodule

// File: tb/tb_hazard_tag_pipe.sv
// tb_hazard_tag_pipe: directed scenario tasks with hand-computed expectations.
module tb_hazard_tag_pipe;
  localparam int REG_W = 4;
  localparam int CNT_W = 4;
  logic clk = 0, reset = 1;
  logic ValidD, RegWriteD, MemtoRegD, PCSrcD, CondExE, StallD, FlushE, CntClr;
  logic [REG_W-1:0] RA1D, RA2D, WA3D;
  logic [REG_W-1:0] RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, MemtoRegE, PCSrcE, RegWriteM, MemtoRegM, PCSrcM;
  logic RegWriteW, MemtoRegW, PCSrcW, ValidE, ValidM, ValidW;
  logic [CNT_W-1:0] StallCnt, FlushCnt, RetireCnt;
  logic [5*REG_W+12+3*CNT_W-1:0] all_out;
  int checks = 0, failures = 0;

  hazard_tag_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD), .CondExE(CondExE),
    .StallD(StallD), .FlushE(FlushE), .CntClr(CntClr),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .PCSrcM(PCSrcM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
    .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt), .RetireCnt(RetireCnt));

  assign all_out = {RA1E, RA2E, WA3E, WA3M, WA3W, RegWriteE, MemtoRegE, PCSrcE,
                    RegWriteM, MemtoRegM, PCSrcM, RegWriteW, MemtoRegW, PCSrcW,
                    ValidE, ValidM, ValidW, StallCnt, FlushCnt, RetireCnt};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ValidD = 0; RA1D = 0; RA2D = 0; WA3D = 0; RegWriteD = 0; MemtoRegD = 0; PCSrcD = 0;
    CondExE = 1; StallD = 0; FlushE = 0; CntClr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      {ValidD, RegWriteD, MemtoRegD, PCSrcD, CondExE, StallD, FlushE, CntClr} = 8'($urandom);
      RA1D = 4'($urandom); RA2D = 4'($urandom); WA3D = 4'($urandom);
      tick();
    end
    checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    reset = 0;
    clear_inputs();
    CondExE = 0;
    tick(); tick();
    checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_idle got=%h exp=0", all_out); end
  endtask

  task automatic test_straight();
    do_reset();
    ValidD = 1; WA3D = 5; RA1D = 2; RA2D = 9; RegWriteD = 1;
    tick();
    clear_inputs();
    checks++; if ({WA3E, RA1E, RA2E, RegWriteE, ValidE} !== {4'd5, 4'd2, 4'd9, 2'b11})
      begin failures++; $display("FAIL straight_e got=%h exp=%h", {WA3E, RA1E, RA2E, RegWriteE, ValidE}, {4'd5, 4'd2, 4'd9, 2'b11}); end
    tick();
    checks++; if ({WA3M, RegWriteM, ValidM, WA3E, ValidE} !== {4'd5, 2'b11, 4'd0, 1'b0})
      begin failures++; $display("FAIL straight_m got=%h exp=%h", {WA3M, RegWriteM, ValidM, WA3E, ValidE}, {4'd5, 2'b11, 4'd0, 1'b0}); end
    tick();
    checks++; if ({WA3W, RegWriteW, ValidW, RetireCnt} !== {4'd5, 2'b11, 4'd0})
      begin failures++; $display("FAIL straight_w got=%h exp=%h", {WA3W, RegWriteW, ValidW, RetireCnt}, {4'd5, 2'b11, 4'd0}); end
    tick();
    checks++; if (RetireCnt !== 4'd1) begin failures++; $display("FAIL straight_retire got=%0d exp=1", RetireCnt); end
    tick();
    checks++; if ({RetireCnt, ValidW} !== {4'd1, 1'b0}) begin failures++; $display("FAIL straight_retire_hold got=%h exp=%h", {RetireCnt, ValidW}, {4'd1, 1'b0}); end
  endtask

  task automatic test_load_use();
    do_reset();
    ValidD = 1; WA3D = 3; MemtoRegD = 1; RegWriteD = 1;
    tick();
    checks++; if ({MemtoRegE, WA3E} !== {1'b1, 4'd3}) begin failures++; $display("FAIL lu_load_e got=%h exp=%h", {MemtoRegE, WA3E}, {1'b1, 4'd3}); end
    clear_inputs();
    ValidD = 1; RA1D = 3; RegWriteD = 1; WA3D = 8; StallD = 1; FlushE = 1;
    tick();
    clear_inputs();
    checks++; if ({ValidE, MemtoRegE, RegWriteE, RA1E, WA3E} !== 11'd0)
      begin failures++; $display("FAIL lu_bubble got=%h exp=0", {ValidE, MemtoRegE, RegWriteE, RA1E, WA3E}); end
    checks++; if ({MemtoRegM, WA3M} !== {1'b1, 4'd3}) begin failures++; $display("FAIL lu_load_m got=%h exp=%h", {MemtoRegM, WA3M}, {1'b1, 4'd3}); end
    checks++; if ({StallCnt, FlushCnt} !== {4'd1, 4'd0}) begin failures++; $display("FAIL lu_counters got=%h exp=%h", {StallCnt, FlushCnt}, {4'd1, 4'd0}); end
    tick();
    checks++; if ({StallCnt, FlushCnt} !== {4'd1, 4'd0}) begin failures++; $display("FAIL lu_counters_hold got=%h exp=%h", {StallCnt, FlushCnt}, {4'd1, 4'd0}); end
  endtask

  task automatic test_cond_fail();
    do_reset();
    ValidD = 1; RegWriteD = 1; PCSrcD = 1; MemtoRegD = 1; WA3D = 6; CondExE = 0;
    tick();
    clear_inputs();
    CondExE = 0;
    checks++; if ({RegWriteE, PCSrcE, MemtoRegE} !== 3'b111) begin failures++; $display("FAIL cf_raw_e got=%b exp=111", {RegWriteE, PCSrcE, MemtoRegE}); end
    tick();
    CondExE = 1;
    checks++; if ({RegWriteM, PCSrcM, MemtoRegM, ValidM, WA3M} !== {4'b0001, 4'd6})
      begin failures++; $display("FAIL cf_gated_m got=%h exp=%h", {RegWriteM, PCSrcM, MemtoRegM, ValidM, WA3M}, {4'b0001, 4'd6}); end
    tick();
    checks++; if ({ValidW, RegWriteW, PCSrcW, MemtoRegW} !== 4'b1000) begin failures++; $display("FAIL cf_w got=%b exp=1000", {ValidW, RegWriteW, PCSrcW, MemtoRegW}); end
    tick();
    checks++; if (RetireCnt !== 4'd1) begin failures++; $display("FAIL cf_retire got=%0d exp=1", RetireCnt); end
  endtask

  task automatic test_branch_flush();
    do_reset();
    ValidD = 1; WA3D = 7; RA2D = 5; RegWriteD = 1; PCSrcD = 1; FlushE = 1;
    tick();
    clear_inputs();
    checks++; if ({WA3E, RA2E, ValidE, RegWriteE, PCSrcE} !== 11'd0)
      begin failures++; $display("FAIL bf_bubble got=%h exp=0", {WA3E, RA2E, ValidE, RegWriteE, PCSrcE}); end
    checks++; if ({FlushCnt, StallCnt} !== {4'd1, 4'd0}) begin failures++; $display("FAIL bf_counters got=%h exp=%h", {FlushCnt, StallCnt}, {4'd1, 4'd0}); end
    ValidD = 0; RegWriteD = 1; PCSrcD = 1; WA3D = 4;
    tick();
    clear_inputs();
    checks++; if ({ValidE, RegWriteE, PCSrcE, WA3E, FlushCnt} !== {3'b000, 4'd4, 4'd1})
      begin failures++; $display("FAIL bf_invalid_mask got=%h exp=%h", {ValidE, RegWriteE, PCSrcE, WA3E, FlushCnt}, {3'b000, 4'd4, 4'd1}); end
  endtask

  task automatic test_saturation();
    do_reset();
    StallD = 1;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (StallCnt !== 4'd15) begin failures++; $display("FAIL sat_stall got=%0d exp=15", StallCnt); end
    CntClr = 1;
    tick();
    checks++; if (StallCnt !== 4'd0) begin failures++; $display("FAIL sat_clear got=%0d exp=0", StallCnt); end
    CntClr = 0;
    tick();
    StallD = 0;
    checks++; if (StallCnt !== 4'd1) begin failures++; $display("FAIL sat_restart got=%0d exp=1", StallCnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      ValidD = 1; RegWriteD = 1; WA3D = 4'(i);
      tick();
    end
    clear_inputs();
    checks++; if ({WA3E, WA3M, WA3W, ValidE, ValidM, ValidW} !== {4'd3, 4'd2, 4'd1, 3'b111})
      begin failures++; $display("FAIL b2b_stages got=%h exp=%h", {WA3E, WA3M, WA3W, ValidE, ValidM, ValidW}, {4'd3, 4'd2, 4'd1, 3'b111}); end
    reset = 1;
    tick();
    reset = 0;
    checks++; if (all_out !== '0) begin failures++; $display("FAIL b2b_midreset got=%h exp=0", all_out); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_straight();
    test_load_use();
    test_cond_fail();
    test_branch_flush();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
